// File: rtl/layer17_bias_relu_acc_if.sv
// Stream bundle between the layer-17 adder trees / bias constants and the
// activation stage: psum beats in, one registered activation word out.
interface layer17_bias_relu_acc_if #(
   parameter int N  = 16,
   parameter int DW = 18
);
   logic [N*DW-1:0] bias;
   logic [N*DW-1:0] psum;
   logic            in_valid;
   logic            in_ready;
   logic [N*DW-1:0] out_data;
   logic            out_valid;
   logic            out_ready;
   logic            group_done;

   modport master (
      output bias, psum, in_valid, out_ready,
      input  in_ready, out_data, out_valid, group_done
   );

   modport slave (
      input  bias, psum, in_valid, out_ready,
      output in_ready, out_data, out_valid, group_done
   );
endinterface

// File: rtl/layer17_bias_relu_acc.sv
// Layer-17 accumulate / bias-add / ReLU / saturate stage. N_PASS psum beats
// per group are summed onto the bias, then clamped into one activation word.

// One lane: accumulator plus the registered, clamped activation.
module l17_lane #(
   parameter int DW    = 18,
   parameter int ACC_W = 22,
   parameter bit RELU  = 1'b1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          accept,
   input  logic          first,
   input  logic          last,
   input  logic [DW-1:0] bias,
   input  logic [DW-1:0] psum,
   output logic [DW-1:0] out
);
   localparam logic signed [ACC_W-1:0] SMAX = ACC_W'((64'sd1 <<< (DW-1)) - 64'sd1);
   localparam logic signed [ACC_W-1:0] SMIN = ~SMAX;

   logic signed [ACC_W-1:0] acc_q, acc_d;
   logic signed [ACC_W-1:0] acc_nx, base, bias_x, psum_x, rl;
   logic        [DW-1:0]    out_q, out_d, sat;

   assign bias_x = {{(ACC_W-DW){bias[DW-1]}}, bias};
   assign psum_x = {{(ACC_W-DW){psum[DW-1]}}, psum};

   always_comb begin
      base   = first ? bias_x : acc_q;
      acc_nx = base + psum_x;
      rl     = (RELU && acc_nx < 0) ? '0 : acc_nx;
      if (rl > SMAX)      sat = SMAX[DW-1:0];
      else if (rl < SMIN) sat = SMIN[DW-1:0];
      else                sat = rl[DW-1:0];
      acc_d = accept ? acc_nx : acc_q;
      out_d = (accept && last) ? sat : out_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_q <= '0;
         out_q <= '0;
      end else begin
         acc_q <= acc_d;
         out_q <= out_d;
      end
   end

   assign out = out_q;
endmodule

module layer17_bias_relu_acc #(
   parameter int N_adder_tree = 16,
   parameter int DW           = 18,
   parameter int N_PASS       = 4,
   parameter int ACC_W        = 22,
   parameter bit RELU         = 1'b1
) (
   input logic                   clk,
   input logic                   rst_n,
   layer17_bias_relu_acc_if.slave bus
);
   localparam int CW = (N_PASS > 1) ? $clog2(N_PASS) : 1;

   typedef enum logic {ACC = 1'b0, OUT = 1'b1} state_t;

   state_t          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            accept, first, last;

   assign accept = bus.in_valid && (state_q == ACC);
   assign first  = (cnt_q == '0);
   assign last   = (cnt_q == CW'(N_PASS-1));

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         ACC: if (accept) begin
            if (last) begin
               cnt_d   = '0;
               state_d = OUT;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         OUT: if (bus.out_ready) state_d = ACC;
         default: state_d = ACC;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ACC;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Handshake outputs depend on state only, so in_ready never waits on in_valid.
   assign bus.in_ready   = (state_q == ACC);
   assign bus.out_valid  = (state_q == OUT);
   assign bus.group_done = (state_q == OUT) && bus.out_ready;

   for (genvar i = 0; i < N_adder_tree; i++) begin : g_lane
      l17_lane #(.DW(DW), .ACC_W(ACC_W), .RELU(RELU)) u_lane (
         .clk    (clk),
         .rst_n  (rst_n),
         .accept (accept),
         .first  (first),
         .last   (last),
         .bias   (bus.bias[DW*i +: DW]),
         .psum   (bus.psum[DW*i +: DW]),
         .out    (bus.out_data[DW*i +: DW])
      );
   end
endmodule

// File: tb/tb_layer17_bias_relu_acc.sv
// Bench for layer17_bias_relu_acc: RELU=1 and RELU=0 instances share stimulus
// and are checked against an arithmetic per-lane reference.
module tb_layer17_bias_relu_acc;
   localparam int N  = 16;
   localparam int DW = 18;
   localparam int NP = 4;
   localparam int W  = N*DW;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   layer17_bias_relu_acc_if #(.N(N), .DW(DW)) if_r ();
   layer17_bias_relu_acc_if #(.N(N), .DW(DW)) if_n ();

   layer17_bias_relu_acc #(.N_adder_tree(N), .DW(DW), .N_PASS(NP), .ACC_W(22), .RELU(1'b1))
      u_relu (.clk(clk), .rst_n(rst_n), .bus(if_r));
   layer17_bias_relu_acc #(.N_adder_tree(N), .DW(DW), .N_PASS(NP), .ACC_W(22), .RELU(1'b0))
      u_lin  (.clk(clk), .rst_n(rst_n), .bus(if_n));

   logic [W-1:0] bias_v, psum_v;
   logic         in_valid_v, out_ready_v;
   assign if_r.bias = bias_v;      assign if_n.bias = bias_v;
   assign if_r.psum = psum_v;      assign if_n.psum = psum_v;
   assign if_r.in_valid = in_valid_v;   assign if_n.in_valid = in_valid_v;
   assign if_r.out_ready = out_ready_v; assign if_n.out_ready = out_ready_v;

   int bias_a [N];
   int psum_a [NP][N];
   int n_run = 0, n_fail = 0;

   task automatic chk(input string tag, input logic [W-1:0] act, input logic [W-1:0] exp);
      n_run++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   // Reference: bias + sum of beats in plain integers, then ReLU, then clamp.
   function automatic logic [W-1:0] model(input bit relu);
      logic [W-1:0] r;
      r = '0;
      for (int i = 0; i < N; i++) begin
         int s;
         s = bias_a[i];
         for (int b = 0; b < NP; b++) s += psum_a[b][i];
         if (relu && s < 0) s = 0;
         if (s > 131071)  s = 131071;
         if (s < -131072) s = -131072;
         r[DW*i +: DW] = s[DW-1:0];
      end
      return r;
   endfunction

   function automatic logic [DW-1:0] lane(input logic [W-1:0] v, input int i);
      return v[DW*i +: DW];
   endfunction

   task automatic pack_bias();
      for (int i = 0; i < N; i++) bias_v[DW*i +: DW] = bias_a[i][DW-1:0];
   endtask

   task automatic pack_psum(input int b);
      for (int i = 0; i < N; i++) psum_v[DW*i +: DW] = psum_a[b][i][DW-1:0];
   endtask

   // gap: 0 continuous, 1 toggling, 2 random. hold: cycles out_ready stays low.
   task automatic run_group(input string tag, input int gap, input int hold, output int cyc);
      int b;
      bit acc;
      logic [W-1:0] rr, rn;
      b = 0; cyc = 0; out_ready_v = 1'b0;
      pack_bias();
      while (b < NP && cyc < 200) begin
         @(negedge clk);
         pack_psum(b);
         in_valid_v = (gap == 0) ? 1'b1 : (gap == 1) ? ((cyc % 2) == 0) : 1'($urandom_range(0, 1));
         acc = in_valid_v && if_r.in_ready;
         @(posedge clk);
         if (acc) b++;
         cyc++;
      end
      if (cyc >= 200) chk({tag, "_timeout"}, W'(cyc), W'(0));
      @(negedge clk);
      in_valid_v = 1'b1;
      psum_v = {9{$urandom()}};
      rr = if_r.out_data; rn = if_n.out_data;
      chk({tag, "_vld"},   W'({if_r.out_valid, if_n.out_valid}), W'(2'b11));
      chk({tag, "_rdy0"},  W'({if_r.in_ready, if_n.in_ready}), W'(0));
      chk({tag, "_relu"},  rr, model(1'b1));
      chk({tag, "_lin"},   rn, model(1'b0));
      for (int h = 0; h < hold; h++) begin
         @(posedge clk);
         @(negedge clk);
         psum_v = {9{$urandom()}};
         chk({tag, "_hold"}, W'({if_r.out_valid, if_r.in_ready, if_r.group_done}), W'(3'b100));
         chk({tag, "_hold_d"}, {if_r.out_data ^ rr} | {if_n.out_data ^ rn}, W'(0));
      end
      out_ready_v = 1'b1;
      #1;
      chk({tag, "_gd"}, W'({if_r.group_done, if_n.group_done}), W'(2'b11));
      @(posedge clk);
      @(negedge clk);
      chk({tag, "_post"}, W'({if_r.out_valid, if_r.group_done, if_r.in_ready}), W'(3'b001));
      chk({tag, "_keep"}, if_r.out_data, rr);
      in_valid_v = 1'b0;
      out_ready_v = 1'b0;
   endtask

   task automatic fill(input int bv, input int pv);
      for (int i = 0; i < N; i++) begin
         bias_a[i] = bv;
         for (int b = 0; b < NP; b++) psum_a[b][i] = pv;
      end
   endtask

   int cyc;
   int gd_cnt = 0;
   always @(posedge clk) if (if_r.group_done) gd_cnt++;

   initial begin
      rst_n = 1'b0; in_valid_v = 1'b0; out_ready_v = 1'b0;
      bias_v = '0; psum_v = '0;
      repeat (2) @(negedge clk);
      in_valid_v = 1'b1;
      @(negedge clk);
      chk("rst_out", {if_r.out_data | if_n.out_data}, W'(0));
      chk("rst_flags", W'({if_r.out_valid, if_r.group_done, if_r.in_ready}), W'(3'b001));
      in_valid_v = 1'b0;
      rst_n = 1'b1;

      // basic group
      fill(100, 0);
      for (int i = 0; i < N; i++) begin
         psum_a[0][i] = 10; psum_a[1][i] = 20; psum_a[2][i] = 30; psum_a[3][i] = 40;
      end
      gd_cnt = 0;
      run_group("basic", 0, 0, cyc);
      chk("basic_lat", W'(cyc), W'(NP));
      chk("basic_200", W'(lane(if_r.out_data, 5)), W'(200));
      chk("basic_gdcnt", W'(gd_cnt), W'(1));

      // ReLU on lane 0
      fill(0, 0);
      bias_a[0] = -500;
      for (int b = 0; b < NP; b++) psum_a[b][0] = 100;
      run_group("relu", 0, 0, cyc);
      chk("relu_l0", W'(lane(if_r.out_data, 0)), W'(0));
      chk("lin_l0", W'(lane(if_n.out_data, 0)), W'(18'h3FF9C));

      // saturation lanes 1 and 2
      fill(0, 0);
      bias_a[1] = 131071; bias_a[2] = -131072;
      for (int b = 0; b < NP; b++) begin psum_a[b][1] = 131071; psum_a[b][2] = -131072; end
      run_group("sat", 0, 0, cyc);
      chk("sat_hi", W'(lane(if_n.out_data, 1)), W'(18'h1FFFF));
      chk("sat_lo", W'(lane(if_n.out_data, 2)), W'(18'h20000));

      // bubbles and back-pressure with random data
      for (int i = 0; i < N; i++) begin
         bias_a[i] = $urandom_range(0, 4000) - 2000;
         for (int b = 0; b < NP; b++) psum_a[b][i] = $urandom_range(0, 4000) - 2000;
      end
      run_group("bubble", 1, 0, cyc);
      run_group("bpress", 0, 10, cyc);

      // reset mid-group after two accepted beats
      fill(7, 9);
      pack_bias();
      for (int b = 0; b < 2; b++) begin
         @(negedge clk); pack_psum(b); in_valid_v = 1'b1;
      end
      @(negedge clk);
      in_valid_v = 1'b0;
      rst_n = 1'b0;
      #1;
      chk("mrst_out", {if_r.out_data | if_n.out_data}, W'(0));
      chk("mrst_flags", W'({if_r.out_valid, if_r.group_done, if_r.in_ready}), W'(3'b001));
      @(negedge clk);
      rst_n = 1'b1;
      fill(50, 3);
      run_group("fresh", 0, 0, cyc);

      // lane independence
      for (int i = 0; i < N; i++) begin
         bias_a[i] = i * 1000;
         for (int b = 0; b < NP; b++) psum_a[b][i] = i;
      end
      run_group("lanes", 0, 0, cyc);
      for (int i = 0; i < N; i++) chk($sformatf("lane%0d", i), W'(lane(if_r.out_data, i)), W'(1004 * i));

      // random full-range groups
      for (int g = 0; g < 20; g++) begin
         for (int i = 0; i < N; i++) begin
            bias_a[i] = int'($urandom_range(0, 262143)) - 131072;
            for (int b = 0; b < NP; b++) psum_a[b][i] = int'($urandom_range(0, 262143)) - 131072;
         end
         run_group($sformatf("rnd%0d", g), 2, $urandom_range(0, 3), cyc);
      end

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end
endmodule

// File: doc/layer17_bias_relu_acc.md
# layer17_bias_relu_acc

Per-lane accumulate, bias-add, ReLU and saturate stage for the layer-17 convolution datapath. Sits directly downstream of the layer-17 adder trees and the per-filter-group bias constant module: it consumes 16 lanes of 18-bit partial sums per beat and the matching 16-lane 18-bit bias vector. It accumulates `N_PASS` partial-sum beats per output group, adds the bias once, and applies ReLU and 18-bit saturation. It presents one registered 16-lane activation word to the next layer's buffer over a valid/ready handshake.

## Interface
- `N_adder_tree`, 16: number of lanes; one lane per adder tree and per bias constant.
- `DW`, 18: lane data width; psum, bias and output share the same signed fixed-point format.
- `N_PASS`, 4: partial-sum beats accumulated per output group; must be ≥1.
- `ACC_W`, 22: accumulator width per lane; must be ≥ DW + clog2(N_PASS+1).
- `RELU`, 1: 1 clamps negatives to 0; 0 passes signed results through the saturation step.
- `clk` input 1: clock; rising edge.
- `rst_n` input 1: asynchronous active-low reset.
- `bias` input N_adder_tree*DW: bias vector; lane i at [DW*(i+1)-1:DW*i]; static during a group.
- `psum` input N_adder_tree*DW: partial sums, same lane packing; signed two's complement.
- `in_valid` input 1: psum beat valid.
- `in_ready` output 1: stage accepts a beat.
- `out_data` output N_adder_tree*DW: activation word, same lane packing.
- `out_valid` output 1: out_data valid.
- `out_ready` input 1: consumer accepts out_data.
- `group_done` output 1: one-cycle pulse on the cycle an output word is consumed.

## Operation
- Two states:
  - ACC: collecting beats. in_ready=1, out_valid=0.
  - OUT: holding a result. in_ready=0, out_valid=1.
- in_ready = (state==ACC); it is combinational from state only and has no dependency on in_valid.
- Beat accepted when in_valid && in_ready.
- Internal pass counter `cnt`, range 0..N_PASS-1.
- When a beat is accepted with cnt==0: acc[i] = sext(bias[i]) + sext(psum[i]).
- When a beat is accepted with cnt>0: acc[i] = acc[i] + sext(psum[i]).
- When a beat is accepted with cnt==N_PASS-1:
  - compute final[i] = acc_next[i];
  - register out_data[i] = sat(relu(final[i]));
  - set cnt to 0 and move to OUT.
  - With N_PASS=1, every accepted beat is both first and last.
- All other accepted beats increment cnt.
- relu(x) = (RELU && x<0) ? 0 : x.
- sat(x) clamps to [-2^(DW-1), 2^(DW-1)-1]. For DW=18 that is [-131072, 131071]. No rounding and no shift are applied: bias and psum share the same binary point.
- In OUT, when out_ready=1: group_done=1 that cycle, state returns to ACC, and out_valid drops the next cycle.
- out_data holds its value after the handshake until the next group's last beat.
- A change in bias mid-group is not sampled except on the cnt==0 beat.
- Reset (asynchronous, any time including mid-group):
  - state=ACC, cnt=0, acc=0;
  - out_data=0, out_valid=0, group_done=0;
  - the partial group is discarded.
- in_ready reads 1 during and after reset, but beats are not accepted while rst_n=0.

## Timing
- Latency: out_valid rises on the clock edge that accepts the last beat, so out_data is visible the cycle after that beat.
- Throughput: N_PASS+1 cycles per group minimum (N_PASS accept cycles plus one OUT cycle with out_ready=1). No overlap between OUT and the next group's first beat.
- out_valid and out_data stay stable while out_valid=1 && out_ready=0, for any duration.
- in_valid gaps are allowed at any point; cnt and acc hold during gaps.
- Output registers have no combinational path from psum or bias.
- group_done is a combinational function of state and out_ready: high only in OUT with out_ready=1.

## Test plan
- **Basic group:** N_PASS=4, all lanes bias=100, psum beats 10, 20, 30, 40, continuous valid, out_ready=1.
  - out_valid at cycle 4 with every lane = 200.
  - group_done pulses once.
  - in_ready low for exactly 1 cycle.
- **ReLU:** lane 0 bias=-500, psums 100×4.
  - lane 0 out = 0 with RELU=1.
  - lane 0 out = -100 (0x3FF9C) with RELU=0.
- **Saturation:**
  - lane 1 bias=131071, psums 131071×4 → lane 1 = 131071;
  - with RELU=0, lane 2 bias=-131072, psums -131072×4 → lane 2 = -131072 (0x20000).
- **Back-pressure and bubbles:**
  - in_valid toggling 1,0,1,0,… → result identical to the continuous case.
  - out_ready held low 10 cycles → out_data and out_valid stable, in_ready=0, extra in_valid beats not consumed.
- **Reset mid-group:** assert rst_n=0 after 2 accepted beats.
  - outputs immediately 0;
  - after release, a fresh 4-beat group yields bias+Σpsum with no residue from the aborted group.
- **Lane independence:** distinct bias per lane (lane i bias = i*1000, psum = i each beat) → lane i out = 1004*i, checked for all 16 lanes.
